ipu_window_sequencer: RTL and testbench
=======================================

Name: ipu_window_sequencer

Overview:
Image processing unit (IPU) front-end that sits directly upstream of the convolution coprocessor.
- Walks a stored grayscale image in raster order.
- For each output pixel, gathers the 5x5 neighbourhood (zero-padded at borders) from image RAM into a 200-bit window.
- Issues one convolution instruction to the coprocessor with ipu_request held high, collects matrix_C, saturates it to 8 bits and writes it to the result RAM.

Parameters:
IMG_W, 160, image width in pixels
IMG_H, 120, image height in pixels
ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
CONV_OPCODE, 4'b0101, opcode placed in instruction[3:0]; instruction[31:4] = 0

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a full-image pass
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last pixel write
rd_en  out  1  image RAM read strobe
rd_addr  out  ADDR_W  image RAM address, y*IMG_W+x
rd_data  in  8  image RAM data, valid exactly 1 cycle after rd_en
wr_en  out  1  result RAM write strobe, one cycle per pixel
wr_addr  out  ADDR_W  result address, y*IMG_W+x
wr_data  out  8  saturated result pixel
instruction  out  32  {28'b0, CONV_OPCODE}, constant
activate_instruction  out  1  one-cycle issue pulse to coprocessor
wait_signal  in  1  coprocessor busy (not in FETCH)
ipu_request  out  1  selects external operands in coprocessor
external_matrix_A  out  200  gathered window; element k=r*5+c at bits [8k+7:8k]; r,c in 0..4; centre is k=12
done_conv  in  1  coprocessor result valid
matrix_C  in  32  signed convolution result

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, activate_instruction=0, ipu_request=0, rd_addr=0, wr_addr=0, wr_data=0, external_matrix_A=0. Reset mid-pass aborts immediately to IDLE with no further writes.
- FSM states: IDLE, GATHER, DRAIN, ISSUE, WAIT_DONE, WAIT_IDLE, WRITE, NEXT.
- IDLE: start=1 -> x=0, y=0, window cleared, go to GATHER. start while not IDLE is ignored.
- GATHER: k steps 0..24, one per cycle. Neighbour coordinates are (x+c-2, y+r-2).
  - In bounds: rd_en=1, rd_addr=ny*IMG_W+nx; the slot index is delayed 1 cycle and rd_data is stored into slot k on the following cycle.
  - Out of bounds: no read; slot k is written 0 on the following cycle.
  - After k=24 go to DRAIN (1 cycle, last slot lands). Gather + drain = 26 cycles.
- ISSUE: entered only when wait_signal=0, otherwise stall here. Pulse activate_instruction for 1 cycle, go to WAIT_DONE.
- ipu_request is high from ISSUE through WAIT_IDLE. external_matrix_A is stable from end of DRAIN through WAIT_IDLE.
- WAIT_DONE: the first cycle with done_conv=1 captures matrix_C, then go to WAIT_IDLE.
- WAIT_IDLE: wait for wait_signal=0, then drop ipu_request and go to WRITE. This guarantees the coprocessor is back in FETCH before the next issue.
- WRITE: wr_en=1 for 1 cycle. wr_addr=y*IMG_W+x. wr_data = 0 if the captured value is <0, 255 if >255, else bits [7:0].
- NEXT: x++; if x wraps past IMG_W-1, x=0 and y++. If the last pixel (IMG_W-1, IMG_H-1) was written, pulse done, busy=0, go to IDLE. Otherwise clear the window and go to GATHER.
- Address arithmetic is unsigned and computed only for in-bounds coordinates. Signed comparisons are used for the border test (nx, ny may be -2..-1 or >= dim).
- done_conv already high on entry to WAIT_DONE is accepted, since it is level-sensitive.

Test Plan:
- IMG_W=4, IMG_H=3, image pixel(i)=i+1. Coprocessor model returns matrix_C = window centre (byte 12). Expect 12 writes, wr_addr 0..11 in order, wr_data=i+1, then one done pulse; busy low afterwards.
- Border padding at pixel (0,0), same image: window bytes for r<2 or c<2 are 0. Byte 18 (r=3,c=3) = pixel(1,1)=6. No rd_addr is issued for out-of-bounds slots, so 9 reads occur for that window.
- Saturation: model returns -5, 300, 255, 0x80000000 on successive pixels -> wr_data 0, 255, 255, 0.
- Handshake stall: hold wait_signal=1 for 10 cycles before ISSUE -> activate_instruction is not pulsed until wait_signal=0, then exactly one pulse. Delay done_conv 40 cycles -> ipu_request stays high and the window is unchanged throughout.
- Reset during WAIT_DONE of pixel 5 -> next cycle all outputs are at reset values and no write occurs. A new start restarts from wr_addr=0.
- start pulsed while busy -> ignored; write sequence and count are unchanged (12).

Source files
------------

// File: rtl/ipu_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ipu_window_sequencer
// Purpose : Raster-walks an image, gathers zero-padded 5x5 windows, hands each
//           window to the convolution coprocessor and writes saturated results.
// Revision: 1.0  initial release
// ============================================================================
module ipu_window_sequencer #(
  parameter int         IMG_W       = 160,
  parameter int         IMG_H       = 120,
  parameter int         ADDR_W      = 15,
  parameter logic [3:0] CONV_OPCODE = 4'b0101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [31:0]       instruction,
  output logic              activate_instruction,
  input  logic              wait_signal,
  output logic              ipu_request,
  output logic [199:0]      external_matrix_A,
  input  logic              done_conv,
  input  logic [31:0]       matrix_C
);

  localparam int CW = ADDR_W + 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GATHER    = 3'd1;
  localparam logic [2:0] S_DRAIN     = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;
  localparam logic [2:0] S_WRITE     = 3'd6;
  localparam logic [2:0] S_NEXT      = 3'd7;

  localparam logic signed [CW-1:0] C_W_S    = CW'(IMG_W);
  localparam logic signed [CW-1:0] C_H_S    = CW'(IMG_H);
  localparam logic signed [CW-1:0] C_TWO    = CW'(2);
  localparam logic [ADDR_W-1:0]    C_W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]    C_X_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0]    C_Y_LAST = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0]    C_ONE_A  = ADDR_W'(1);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_x;
  logic [ADDR_W-1:0] r_y;
  logic [2:0]        r_r;
  logic [2:0]        r_c;
  logic [4:0]        r_k;
  logic              r_slot_vld;
  logic              r_slot_inb;
  logic [4:0]        r_slot_idx;
  logic [199:0]      r_window;
  logic [31:0]       r_result;

  logic signed [CW-1:0] w_nx;
  logic signed [CW-1:0] w_ny;
  logic                 w_inb;
  logic                 w_last_pixel;
  logic [7:0]           w_sat;

  // Neighbour coordinates may go negative at the top/left border, so the
  // border test is done on a signed copy two bits wider than the address.
  assign w_nx = $signed({2'b00, r_x}) + $signed({{(CW-3){1'b0}}, r_c}) - C_TWO;
  assign w_ny = $signed({2'b00, r_y}) + $signed({{(CW-3){1'b0}}, r_r}) - C_TWO;
  assign w_inb = !w_nx[CW-1] && (w_nx < C_W_S) && !w_ny[CW-1] && (w_ny < C_H_S);
  assign w_last_pixel = (r_x == C_X_LAST) && (r_y == C_Y_LAST);

  always_comb begin
    if (r_result[31])
      w_sat = 8'h00;
    else if (|r_result[30:8])
      w_sat = 8'hFF;
    else
      w_sat = r_result[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_GATHER;
      S_GATHER:    if (r_k == 5'd24) w_next = S_DRAIN;
      S_DRAIN:     w_next = S_ISSUE;
      S_ISSUE:     if (!wait_signal) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (done_conv) w_next = S_WAIT_IDLE;
      S_WAIT_IDLE: if (!wait_signal) w_next = S_WRITE;
      S_WRITE:     w_next = S_NEXT;
      S_NEXT:      w_next = w_last_pixel ? S_IDLE : S_GATHER;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy                 = (r_state != S_IDLE);
    done                 = (r_state == S_NEXT) && w_last_pixel;
    rd_en                = (r_state == S_GATHER) && w_inb;
    rd_addr              = '0;
    if (rd_en)
      rd_addr = w_ny[ADDR_W-1:0] * C_W_A + w_nx[ADDR_W-1:0];
    activate_instruction = (r_state == S_ISSUE) && !wait_signal;
    ipu_request          = (r_state == S_ISSUE) || (r_state == S_WAIT_DONE) ||
                           (r_state == S_WAIT_IDLE);
    wr_en                = (r_state == S_WRITE);
    wr_addr              = '0;
    wr_data              = 8'h00;
    if (wr_en) begin
      wr_addr = r_y * C_W_A + r_x;
      wr_data = w_sat;
    end
  end

  // Slot index and border flag trail the read by one cycle to line up with
  // the RAM's read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_r        <= 3'd0;
      r_c        <= 3'd0;
      r_k        <= 5'd0;
      r_slot_vld <= 1'b0;
      r_slot_inb <= 1'b0;
      r_slot_idx <= 5'd0;
      r_window   <= '0;
      r_result   <= 32'd0;
    end else begin
      r_slot_vld <= 1'b0;
      if (r_slot_vld)
        r_window[8*r_slot_idx +: 8] <= r_slot_inb ? rd_data : 8'h00;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x      <= '0;
            r_y      <= '0;
            r_r      <= 3'd0;
            r_c      <= 3'd0;
            r_k      <= 5'd0;
            r_window <= '0;
          end
        end
        S_GATHER: begin
          r_slot_vld <= 1'b1;
          r_slot_idx <= r_k;
          r_slot_inb <= w_inb;
          r_k        <= r_k + 5'd1;
          if (r_c == 3'd4) begin
            r_c <= 3'd0;
            r_r <= r_r + 3'd1;
          end else begin
            r_c <= r_c + 3'd1;
          end
        end
        S_WAIT_DONE: begin
          if (done_conv)
            r_result <= matrix_C;
        end
        S_NEXT: begin
          if (!w_last_pixel) begin
            if (r_x == C_X_LAST) begin
              r_x <= '0;
              r_y <= r_y + C_ONE_A;
            end else begin
              r_x <= r_x + C_ONE_A;
            end
            r_r      <= 3'd0;
            r_c      <= 3'd0;
            r_k      <= 5'd0;
            r_window <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign instruction       = {28'd0, CONV_OPCODE};
  assign external_matrix_A = r_window;

endmodule
`default_nettype wire

// File: tb/tb_ipu_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ipu_window_sequencer
// Purpose : Self-checking bench with image RAM and coprocessor models.
// Revision: 1.0  initial release
// ============================================================================
module tb_ipu_window_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, rd_en, wr_en, activate_instruction, ipu_request;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data, wr_data;
  logic [31:0]   instruction, matrix_C;
  logic [199:0]  external_matrix_A;
  logic          wait_signal, done_conv;

  always #5 clk = ~clk;

  ipu_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .instruction(instruction), .activate_instruction(activate_instruction),
    .wait_signal(wait_signal), .ipu_request(ipu_request),
    .external_matrix_A(external_matrix_A), .done_conv(done_conv), .matrix_C(matrix_C)
  );

  typedef struct { logic [31:0] c; logic [7:0] exp; } sat_vec_t;

  logic [7:0]  img [N];
  sat_vec_t    tbl [N];
  logic [31:0] rc  [N];
  int          mode = 0;
  int          lat  = 3;
  logic        force_wait = 1'b0;
  logic        rnd_en = 1'b0;
  logic        rnd_wait = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [199:0] ref_win(input int p);
    logic [199:0] w = '0;
    int x = p % W;
    int y = p / W;
    for (int k = 0; k < 25; k++) begin
      int nx = x + (k % 5) - 2;
      int ny = y + (k / 5) - 2;
      if (nx >= 0 && nx < W && ny >= 0 && ny < H) w[8*k +: 8] = img[ny*W + nx];
    end
    return w;
  endfunction

  function automatic int ref_reads(input int p);
    int cnt = 0;
    for (int k = 0; k < 25; k++) begin
      int nx = (p % W) + (k % 5) - 2;
      int ny = (p / W) + (k / 5) - 2;
      if (nx >= 0 && nx < W && ny >= 0 && ny < H) cnt++;
    end
    return cnt;
  endfunction

  function automatic logic [7:0] sat_ref(input logic [31:0] c);
    int v = int'(signed'(c));
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return c[7:0];
  endfunction

  function automatic logic [7:0] exp_data(input int p);
    if (mode == 0) return img[p];
    if (mode == 1) return tbl[p].exp;
    return sat_ref(rc[p]);
  endfunction

  // ---------------- image RAM: one cycle read latency ----------------
  always @(posedge clk)
    rd_data <= (rd_en && rd_addr < AW'(N)) ? img[rd_addr[3:0]] : 8'h00;

  // ---------------- coprocessor model ----------------
  logic        cp_busy = 1'b0;
  int          cp_cnt = 0;
  int          iss_cnt = 0;
  logic [31:0] cp_res = '0;

  always @(posedge clk) rnd_wait <= rnd_en && ($urandom_range(0, 3) == 0);
  assign wait_signal = cp_busy | force_wait | rnd_wait;

  always @(posedge clk) begin
    if (reset) begin
      cp_busy <= 1'b0; cp_cnt <= 0; iss_cnt <= 0; done_conv <= 1'b0; matrix_C <= '0;
    end else begin
      done_conv <= 1'b0;
      if (activate_instruction) begin
        cp_busy <= 1'b1;
        cp_cnt  <= lat;
        iss_cnt <= iss_cnt + 1;
        if (mode == 0)      cp_res <= {24'd0, external_matrix_A[103:96]};
        else if (mode == 1) cp_res <= tbl[iss_cnt % N].c;
        else                cp_res <= rc[iss_cnt % N];
      end else if (cp_busy) begin
        if (cp_cnt == 0) cp_busy <= 1'b0;
        else begin
          cp_cnt <= cp_cnt - 1;
          if (cp_cnt == 1) begin
            done_conv <= 1'b1;
            matrix_C  <= cp_res;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int           wcount = 0, reads = 0, acts = 0, dones = 0, last_writes = 0, reads_first = 0;
  bit           pend = 0, got_done = 0, have_snap = 0;
  logic [199:0] snap = '0, win_first = '0;

  always @(negedge clk) begin
    if (reset) begin
      wcount = 0; reads = 0; acts = 0; pend = 0; got_done = 0; have_snap = 0;
    end else begin
      if (rd_en) reads++;
      if (activate_instruction) begin
        check("issue_while_wait", wait_signal, 0);
        check("window", external_matrix_A, ref_win(wcount));
        check("read_count", reads, ref_reads(wcount));
        if (wcount == 0) begin
          win_first = external_matrix_A;
          reads_first = reads;
        end
        acts++; pend = 1; got_done = 0; snap = external_matrix_A; have_snap = 1;
      end else if (have_snap) begin
        check("window_stable", external_matrix_A, snap);
      end
      if (pend) begin
        check("ipu_request_held", ipu_request, 1);
        if (done_conv) got_done = 1;
        else if (got_done && !wait_signal) pend = 0;
      end
      if (wr_en) begin
        check("wr_addr", wr_addr, wcount);
        check("wr_data", wr_data, exp_data(wcount));
        check("ipu_request_low_at_write", ipu_request, 0);
        check("one_issue_per_pixel", acts, 1);
        wcount++; reads = 0; acts = 0; have_snap = 0;
      end
      if (done) begin
        check("done_after_last_write", wcount, N);
        dones++; last_writes = wcount; wcount = 0; reads = 0;
      end
    end
  end

  // ---------------- sequences ----------------
  task automatic check_reset_outs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_activate", activate_instruction, 0);
    check("rst_ipu_request", ipu_request, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_matrix_A", external_matrix_A, 0);
  endtask

  task automatic run_pass(input int budget, input int restart_at, input int hold_wait);
    int d0 = dones;
    int cyc = 0;
    force_wait = (hold_wait > 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (dones == d0 && cyc < budget) begin
      start = (cyc == restart_at);
      if (hold_wait > 0 && cyc == hold_wait) begin
        check("no_issue_during_stall", acts + wcount, 0);
        force_wait = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    force_wait = 1'b0;
    check("pass_finished", dones != d0, 1);
    tick();
    check("busy_after_done", busy, 0);
    check("single_done", dones - d0, 1);
    check("writes_per_pass", last_writes, N);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] pad_or;
    int         cyc;

    for (int i = 0; i < N; i++) img[i] = 8'(i + 1);
    tbl[0]  = '{32'hFFFF_FFFB, 8'd0};
    tbl[1]  = '{32'd300,       8'd255};
    tbl[2]  = '{32'd255,       8'd255};
    tbl[3]  = '{32'h8000_0000, 8'd0};
    tbl[4]  = '{32'd0,         8'd0};
    tbl[5]  = '{32'd1,         8'd1};
    tbl[6]  = '{32'd128,       8'd128};
    tbl[7]  = '{32'd254,       8'd254};
    tbl[8]  = '{32'd256,       8'd255};
    tbl[9]  = '{32'hFFFF_FFFF, 8'd0};
    tbl[10] = '{32'h7FFF_FFFF, 8'd255};
    tbl[11] = '{32'h1234_5678, 8'd255};

    reset = 1'b1;
    repeat (3) tick();
    check_reset_outs();
    reset = 1'b0;
    tick();
    check("instruction", instruction, 32'h0000_0005);

    // centre passthrough, with a stray start while busy
    mode = 0; lat = 3;
    run_pass(5000, 100, 0);
    pad_or = 8'h00;
    for (int k = 0; k < 25; k++)
      if ((k / 5) < 2 || (k % 5) < 2) pad_or = pad_or | win_first[8*k +: 8];
    check("border_pad_zero", pad_or, 0);
    check("byte18_pixel11", win_first[151:144], 8'd6);
    check("byte12_centre", win_first[103:96], 8'd1);
    check("reads_first_window", reads_first, 9);

    // saturation table
    mode = 1; lat = 2;
    run_pass(5000, -1, 0);

    // handshake stall and long coprocessor latency
    mode = 0; lat = 40;
    run_pass(8000, -1, 40);

    // reset in WAIT_DONE of pixel 5
    mode = 0; lat = 40;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(wcount == 5 && pend) && cyc < 5000) begin tick(); cyc++; end
    check("reach_pixel5_issue", wcount == 5 && pend, 1);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check_reset_outs();
    reset = 1'b0;
    repeat (60) tick();
    check("no_write_after_reset", wcount, 0);
    check("idle_after_reset", busy, 0);
    lat = 3;
    run_pass(5000, -1, 0);

    // randomized passes
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < N; i++) begin
        img[i] = 8'($urandom);
        case ($urandom_range(0, 3))
          0:       rc[i] = -32'($urandom_range(1, 1000));
          1:       rc[i] = 32'(256 + $urandom_range(0, 100000));
          2:       rc[i] = 32'($urandom_range(0, 255));
          default: rc[i] = $urandom;
        endcase
      end
      mode = 2;
      lat = $urandom_range(1, 6);
      rnd_en = 1'b1;
      run_pass(8000, -1, 0);
      rnd_en = 1'b0;
      repeat (2) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
